rca_seq_ctrl: RTL and testbench

//   Multi-precision add/subtract sequencer around one shared 4-bit RCA instance.

---
 rtl/rca_seq_ctrl.sv | 157 +++++++++++++++
 tb/tb_rca_seq_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rca_seq_ctrl.sv
// rca_seq_ctrl: multi-precision add/subtract sequencer. One shared 4-bit
// ripple-carry adder is stepped across the operands LSB slice first, with a
// registered carry chaining the slices. Valid/ready on both sides.

// 4-bit ripple-carry adder built from a chain of full adders.
module rca4 (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       c_i,
  output logic [3:0] s_o,
  output logic       c_o
);
  logic [4:0] c;

  assign c[0] = c_i;

  for (genvar i = 0; i < 4; i++) begin : g_fa
    assign s_o[i]   = a_i[i] ^ b_i[i] ^ c[i];
    assign c[i+1]   = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
  end

  assign c_o = c[4];
endmodule

module rca_seq_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int NSLICE = WIDTH / 4;
  localparam int KW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_bad_width
    $error("rca_seq_ctrl: WIDTH must be a multiple of 4 and >= 4");
  end

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e            state_q, state_d;
  logic [KW-1:0]     k_q, k_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [WIDTH-1:0]  sum_q, sum_d;
  logic              carry_q, carry_d;
  logic              cout_q, cout_d;
  logic              ovf_q, ovf_d;

  logic [3:0]        rca_s;
  logic              rca_c;
  logic              last_slice;
  logic              accept;

  assign last_slice = (k_q == KW'(NSLICE - 1));
  assign accept     = in_valid && in_ready;

  // The single shared adder always looks at the current slice k.
  rca4 u_rca (
    .a_i (a_q[{k_q, 2'b00} +: 4]),
    .b_i (b_q[{k_q, 2'b00} +: 4]),
    .c_i (carry_q),
    .s_o (rca_s),
    .c_o (rca_c)
  );

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic: accept -> walk slices -> hold result until taken.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept)     state_d = S_RUN;
      S_RUN:   if (last_slice) state_d = S_DONE;
      S_DONE:  if (out_ready)  state_d = S_IDLE;
      default:                 state_d = S_IDLE;
    endcase
  end

  // Handshake outputs decoded from state; in_ready is also masked by reset.
  always_comb begin
    in_ready  = (state_q == S_IDLE) && !rst;
    out_valid = (state_q == S_DONE);
  end

  // Datapath next-state: subtract is a + ~b + 1, so b is inverted at accept
  // and the carry is seeded with 1; cout/ovf are captured on the MSB slice.
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    k_d     = k_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = sub ? 1'b1 : cin;
          k_d     = '0;
        end
      end
      S_RUN: begin
        sum_d[{k_q, 2'b00} +: 4] = rca_s;
        carry_d                  = rca_c;
        if (last_slice) begin
          cout_d = rca_c;
          ovf_d  = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (rca_s[3] != a_q[WIDTH-1]);
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      k_q     <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      k_q     <= k_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;
endmodule

// File: tb/tb_rca_seq_ctrl.sv
// Bench for rca_seq_ctrl (WIDTH=16): constant vector table, corner-case
// sequences (backpressure, mid-op reset) and random ops vs. an integer model.
module tb_rca_seq_ctrl;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         cin = 1'b0;
  logic         sub = 1'b0;
  logic         out_ready = 1'b1;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         in_ready, out_valid, cout, ovf;
  logic [W-1:0] sum;

  always #5 clk = ~clk;

  rca_seq_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf)
  );

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [W-1:0] a, b;
    logic         ci, su;
    logic [W-1:0] s;
    logic         co, ov;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic. Returns {sum, cout, ovf}.
  function automatic logic [W+1:0] model(input logic [W-1:0] ta, input logic [W-1:0] tb,
                                         input logic tc, input logic ts);
    int ua, ub, sa, sb, ur, sr;
    logic [W-1:0] s;
    logic co, ov;
    ua = int'(ta);
    ub = int'(tb);
    sa = int'($signed(ta));
    sb = int'($signed(tb));
    if (ts) begin
      ur = ua - ub;
      sr = sa - sb;
      co = (ua >= ub);
    end else begin
      ur = ua + ub + int'(tc);
      sr = sa + sb + int'(tc);
      co = (ur > 65535);
    end
    s  = ur[W-1:0];
    ov = (sr > 32767) || (sr < -32768);
    return {s, co, ov};
  endfunction

  // Present an op at a negedge, wait for accept, then count cycles to out_valid.
  // Returns at the negedge where out_valid is seen; lat=0 on timeout.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb,
                        input logic tc, input logic ts, output int lat);
    int n;
    n = 0;
    a = ta; b = tb; cin = tc; sub = ts; in_valid = 1'b1;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (!out_valid) lat = 0;
  endtask

  vec_t          tbl[10];
  logic [W+1:0]  exp_q[$];
  logic [W+1:0]  e;
  int            lat;

  initial begin
    tbl[0] = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0};
    tbl[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    tbl[2] = '{16'h7FFF, 16'h0000, 1'b1, 1'b0, 16'h8000, 1'b0, 1'b1};
    tbl[3] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    tbl[4] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    tbl[5] = '{16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    tbl[6] = '{16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
    tbl[7] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
    tbl[8] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0};
    tbl[9] = '{16'h7FFF, 16'hFFFF, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);
    chk("rst_ovf", ovf, 0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", in_ready, 1);

    // Constant vector table
    for (int i = 0; i < 10; i++) begin
      run_op(tbl[i].a, tbl[i].b, tbl[i].ci, tbl[i].su, lat);
      chk($sformatf("tbl%0d_latency", i), lat, 5);
      chk($sformatf("tbl%0d_sum", i), sum, tbl[i].s);
      chk($sformatf("tbl%0d_cout", i), cout, tbl[i].co);
      chk($sformatf("tbl%0d_ovf", i), ovf, tbl[i].ov);
      @(negedge clk);
      chk($sformatf("tbl%0d_valid_clr", i), out_valid, 0);
    end

    // Backpressure: result held, no accept, in_valid pulse ignored
    out_ready = 1'b0;
    run_op(16'h8000, 16'h0001, 1'b0, 1'b1, lat);
    chk("bp_latency", lat, 5);
    for (int i = 0; i < 10; i++) begin
      chk("bp_out_valid", out_valid, 1);
      chk("bp_sum", sum, 16'h7FFF);
      chk("bp_cout", cout, 1);
      chk("bp_ovf", ovf, 1);
      chk("bp_in_ready", in_ready, 0);
      if (i == 3) begin
        in_valid = 1'b1;
        a = 16'hAAAA;
        sub = 1'b0;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_valid", out_valid, 0);
    chk("bp_release_in_ready", in_ready, 1);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      chk("bp_no_ghost_op", out_valid, 0);
    end

    // Reset during the second RUN cycle
    a = 16'h00FF; b = 16'h0F01; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_in_ready", in_ready, 1);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_sum", sum, 0);
    chk("abort_cout", cout, 0);
    chk("abort_ovf", ovf, 0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("abort_no_valid", out_valid, 0);
    end
    run_op(16'h0001, 16'h0002, 1'b0, 1'b0, lat);
    chk("abort_next_latency", lat, 5);
    chk("abort_next_sum", sum, 16'h0003);
    chk("abort_next_cout", cout, 0);
    chk("abort_next_ovf", ovf, 0);
    @(negedge clk);

    // Random isolated ops vs. model
    for (int i = 0; i < 12; i++) begin
      logic [W-1:0] ra, rb;
      logic rc, rs;
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom_range(0, 1));
      rs = 1'($urandom_range(0, 1));
      e = model(ra, rb, rc, rs);
      run_op(ra, rb, rc, rs, lat);
      chk("rnd_latency", lat, 5);
      chk("rnd_sum", sum, e[W+1:2]);
      chk("rnd_cout", cout, e[1]);
      chk("rnd_ovf", ovf, e[0]);
      @(negedge clk);
    end

    // Back-to-back: in_valid and out_ready held high, 8 random ops
    begin
      int pushed, got, cyc, last_acc;
      bit acc_flag;
      pushed = 0; got = 0; cyc = 0; last_acc = -1; acc_flag = 0;
      out_ready = 1'b1;
      a = W'($urandom); b = W'($urandom);
      cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
      in_valid = 1'b1;
      while (got < 8 && cyc < 200) begin
        if (out_valid) begin
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("b2b_sum", sum, e[W+1:2]);
            chk("b2b_cout", cout, e[1]);
            chk("b2b_ovf", ovf, e[0]);
          end else begin
            chk("b2b_unexpected_valid", out_valid, 0);
          end
          got++;
        end
        if (acc_flag) begin
          if (pushed == 8) in_valid = 1'b0;
          else begin
            a = W'($urandom); b = W'($urandom);
            cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
          end
        end
        acc_flag = 0;
        if (in_ready && in_valid) begin
          if (last_acc >= 0) chk("b2b_period", cyc - last_acc, 6);
          last_acc = cyc;
          exp_q.push_back(model(a, b, cin, sub));
          pushed++;
          acc_flag = 1;
        end
        @(negedge clk);
        cyc++;
      end
      chk("b2b_results", got, 8);
      in_valid = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
